// File: rtl/mm_pkg.sv
// Shared constants and types for the mm datapath: scalar width, lanes per row,
// and the scalar / packed-row types.
package mm_pkg;

    localparam int MM_DW  = 32;
    localparam int MM_NUM = 16;

    typedef logic [MM_DW-1:0] mm_scalar_t;
    typedef logic [MM_NUM-1:0][MM_DW-1:0] mm_row_t;

endpackage

// File: rtl/mm_row_fifo.sv
// DEPTH-entry synchronous row FIFO with wrap-bit pointers; a push into a full
// FIFO is accepted only when a pop frees the head slot in the same cycle.
module mm_row_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Storage is cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/mm_result_packer.sv
// Packs NUM consecutive dot-product scalars into one row and queues rows for a
// ready/valid consumer. Define MM_PACKER_OVF_EN to add the sticky overflow port.
import mm_pkg::*;

module mm_result_packer #(
    parameter int NUM   = MM_NUM,
    parameter int DW    = MM_DW,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DW-1:0]              res_data,
    input  logic                       res_valid,
    input  logic                       flush,
    output logic [DW*NUM-1:0]          row_data,
    output logic                       row_valid,
    input  logic                       row_ready,
    output logic [$clog2(DEPTH+1)-1:0] rows_free
`ifdef MM_PACKER_OVF_EN
    ,
    output logic                       overflow
`endif
);

    localparam int LW = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [NUM-1:0][DW-1:0] asm_q, asm_d, asm_next;
    logic [LW-1:0]          lane_cnt_q, lane_cnt_d;
    logic                   row_done;
    logic                   pop;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;

    // The incoming scalar lands first, so a coincident flush or final lane
    // pushes a row that already contains it.
    always_comb begin
        asm_next = asm_q;
        if (res_valid) begin
            asm_next[lane_cnt_q] = res_data;
        end
        row_done = (res_valid && (lane_cnt_q == LW'(NUM-1))) ||
                   (flush && ((lane_cnt_q != '0) || res_valid));
        if (row_done) begin
            asm_d      = '0;
            lane_cnt_d = '0;
        end else begin
            asm_d      = asm_next;
            lane_cnt_d = lane_cnt_q + LW'(res_valid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q      <= '0;
            lane_cnt_q <= '0;
        end else begin
            asm_q      <= asm_d;
            lane_cnt_q <= lane_cnt_d;
        end
    end

    assign row_valid = !fifo_empty;
    assign pop       = row_valid && row_ready;
    assign rows_free = CW'(DEPTH) - fifo_count;

    mm_row_fifo #(
        .WIDTH (DW*NUM),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (row_done),
        .wdata (asm_next),
        .pop   (pop),
        .rdata (row_data),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef MM_PACKER_OVF_EN
    logic overflow_q, overflow_d;
    logic drop;

    assign drop = row_done && (fifo_count == CW'(DEPTH)) && !pop;

    always_comb begin
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_mm_result_packer.sv
// Directed bench for mm_result_packer: assembly, flush cases, backpressure,
// full push+pop, drop on full, and asynchronous reset mid-row.
import mm_pkg::*;

module tb_mm_result_packer;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [MM_DW-1:0]          res_data;
    logic                      res_valid;
    logic                      flush;
    logic [MM_DW*MM_NUM-1:0]   row_data;
    logic                      row_valid;
    logic                      row_ready;
    logic [1:0]                rows_free;
`ifdef MM_PACKER_OVF_EN
    logic                      overflow;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] fv [16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                            32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                            32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

    mm_result_packer #(
        .NUM   (MM_NUM),
        .DW    (MM_DW),
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_data  (res_data),
        .res_valid (res_valid),
        .flush     (flush),
        .row_data  (row_data),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .rows_free (rows_free)
`ifdef MM_PACKER_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int k);
        mm_row_t r;
        r = row_data;
        return r[k];
    endfunction

    // One scalar per call; res_valid stays continuous across back-to-back calls.
    task automatic scalar(input logic [31:0] v, input logic fl);
        res_data  = v;
        res_valid = 1'b1;
        flush     = fl;
        tick();
        res_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic push_row(input logic [31:0] base);
        for (int i = 0; i < 16; i++) scalar(base + 32'(i), 1'b0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; res_data = '0; res_valid = 1'b0; flush = 1'b0; row_ready = 1'b0;
        #2;
        chk("rst_row_valid", 64'(row_valid), 64'd0);
        chk("rst_row_data_l0", 64'(lane(0)), 64'd0);
        chk("rst_row_data_l15", 64'(lane(15)), 64'd0);
        chk("rst_rows_free", 64'(rows_free), 64'd2);
`ifdef MM_PACKER_OVF_EN
        chk("rst_overflow", 64'(overflow), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Row assembly with row_ready held high
        row_ready = 1'b1;
        for (int i = 0; i < 15; i++) scalar(fv[i], 1'b0);
        chk("asm_not_yet_valid", 64'(row_valid), 64'd0);
        scalar(fv[15], 1'b0);
        chk("asm_valid", 64'(row_valid), 64'd1);
        chk("asm_lane0", 64'(lane(0)), 64'h3F800000);
        chk("asm_lane7", 64'(lane(7)), 64'h41000000);
        chk("asm_lane15", 64'(lane(15)), 64'h41800000);
        chk("asm_free", 64'(rows_free), 64'd1);
        tick();
        chk("asm_popped", 64'(row_valid), 64'd0);
        chk("asm_free_back", 64'(rows_free), 64'd2);

        // Partial flush after 5 scalars
        row_ready = 1'b0;
        for (int i = 0; i < 5; i++) scalar(32'hA0 + 32'(i), 1'b0);
        chk("pf_not_valid", 64'(row_valid), 64'd0);
        do_flush();
        chk("pf_valid", 64'(row_valid), 64'd1);
        for (int k = 0; k < 16; k++)
            chk($sformatf("pf_lane%0d", k), 64'(lane(k)), (k < 5) ? 64'(32'hA0 + 32'(k)) : 64'd0);
        row_ready = 1'b1; tick(); row_ready = 1'b0;
        chk("pf_popped", 64'(row_valid), 64'd0);

        // Flush on the cycle of the third scalar
        scalar(32'hB0, 1'b0);
        scalar(32'hB1, 1'b0);
        scalar(32'hB2, 1'b1);
        chk("fc_valid", 64'(row_valid), 64'd1);
        chk("fc_lane0", 64'(lane(0)), 64'hB0);
        chk("fc_lane2", 64'(lane(2)), 64'hB2);
        chk("fc_lane3", 64'(lane(3)), 64'd0);
        chk("fc_free", 64'(rows_free), 64'd1);
        row_ready = 1'b1; tick(); row_ready = 1'b0;
        do_flush();
        chk("fz_no_row", 64'(row_valid), 64'd0);
        chk("fz_free", 64'(rows_free), 64'd2);
        // lane counter restarted at 0 after the flushes
        scalar(32'hC0, 1'b1);
        chk("fz_restart_lane0", 64'(lane(0)), 64'hC0);
        chk("fz_restart_lane1", 64'(lane(1)), 64'd0);
        row_ready = 1'b1; tick(); row_ready = 1'b0;

        // Backpressure: two rows queue up, head held
        push_row(32'hD00);
        chk("bp_free1", 64'(rows_free), 64'd1);
        chk("bp_head_a", 64'(lane(0)), 64'hD00);
        push_row(32'hE00);
        chk("bp_free0", 64'(rows_free), 64'd0);
        chk("bp_held_l0", 64'(lane(0)), 64'hD00);
        chk("bp_held_l15", 64'(lane(15)), 64'hD0F);
        row_ready = 1'b1;
        tick();
        chk("bp_second_l0", 64'(lane(0)), 64'hE00);
        chk("bp_second_l15", 64'(lane(15)), 64'hE0F);
        chk("bp_free_after1", 64'(rows_free), 64'd1);
        tick();
        chk("bp_empty", 64'(row_valid), 64'd0);
        chk("bp_free_after2", 64'(rows_free), 64'd2);
        row_ready = 1'b0;

        // Full FIFO, final scalar coincides with a pop
        push_row(32'hF00);
        push_row(32'h1000);
        for (int i = 0; i < 15; i++) scalar(32'h2000 + 32'(i), 1'b0);
        chk("pp_full_before", 64'(rows_free), 64'd0);
        row_ready = 1'b1;
        scalar(32'h200F, 1'b0);
        row_ready = 1'b0;
        chk("pp_free", 64'(rows_free), 64'd0);
        chk("pp_head", 64'(lane(0)), 64'h1000);
`ifdef MM_PACKER_OVF_EN
        chk("pp_no_overflow", 64'(overflow), 64'd0);
`endif

        // Full FIFO without pop: third row is dropped
        push_row(32'h3000);
        chk("ov_free", 64'(rows_free), 64'd0);
        chk("ov_head", 64'(lane(0)), 64'h1000);
`ifdef MM_PACKER_OVF_EN
        chk("ov_set", 64'(overflow), 64'd1);
`endif
        row_ready = 1'b1;
        tick();
        chk("ov_next_l0", 64'(lane(0)), 64'h2000);
        chk("ov_next_l15", 64'(lane(15)), 64'h200F);
        tick();
        chk("ov_dropped_absent", 64'(row_valid), 64'd0);
        row_ready = 1'b0;
`ifdef MM_PACKER_OVF_EN
        chk("ov_sticky", 64'(overflow), 64'd1);
`endif

        // Asynchronous reset mid-row
        push_row(32'h4000);
        scalar(32'h5000, 1'b0);
        scalar(32'h5001, 1'b0);
        scalar(32'h5002, 1'b0);
        chk("ar_pre_valid", 64'(row_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_row_valid", 64'(row_valid), 64'd0);
        chk("ar_row_data", 64'(lane(0)), 64'd0);
        chk("ar_rows_free", 64'(rows_free), 64'd2);
`ifdef MM_PACKER_OVF_EN
        chk("ar_overflow", 64'(overflow), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        scalar(32'h6000, 1'b1);
        chk("ar_new_l0", 64'(lane(0)), 64'h6000);
        chk("ar_new_l1", 64'(lane(1)), 64'd0);
        chk("ar_new_free", 64'(rows_free), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
